// File: rtl/qos_pkg.sv
// Shared types and constants for the QoS packet transmitter.
package qos_pkg;

   localparam int unsigned PKT_W   = 4;
   localparam int unsigned CLASS_W = 2;

   localparam logic [CLASS_W-1:0] CLS0 = 2'd0;
   localparam logic [CLASS_W-1:0] CLS1 = 2'd1;
   localparam logic [CLASS_W-1:0] CLS2 = 2'd2;
   localparam logic [CLASS_W-1:0] CLS3 = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      START,
      SGAP,
      PULSE,
      BGAP,
      IPG
   } tx_state_t;

   typedef struct packed {
      logic [CLASS_W-1:0]       cls;
      logic [PKT_W-CLASS_W-1:0] payload;
   } pkt_t;

endpackage

// File: rtl/qos_pkt_tx_if.sv
// Valid/ready packet handshake into the transmitter.
import qos_pkg::*;

interface qos_pkt_tx_if;
   pkt_t pkt_in;
   logic pkt_valid;
   logic pkt_ready;

   modport master (output pkt_in, output pkt_valid, input pkt_ready);
   modport slave  (input pkt_in, input pkt_valid, output pkt_ready);
endinterface

// File: rtl/qos_pkt_fifo.sv
// Synchronous packet FIFO with registered full/empty flags and occupancy count.
import qos_pkg::*;

module qos_pkt_fifo #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               push,
   input  logic [PKT_W-1:0]                   din,
   input  logic                               pop,
   output logic [PKT_W-1:0]                   dout,
   output logic                               full,
   output logic                               empty,
   output logic [$clog2(FIFO_DEPTH + 1)-1:0]  count
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   logic [PKT_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_nxt;
   logic             wr_en;
   logic             rd_en;

   // A full FIFO refuses writes even when a pop happens on the same edge
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (wr_en && !rd_en) begin
         count_nxt = count + CW'(1);
      end else if (!wr_en && rd_en) begin
         count_nxt = count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_nxt;
         full  <= (count_nxt == CW'(FIFO_DEPTH));
         empty <= (count_nxt == CW'(0));
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/qos_pkt_tx.sv
// Packet source for the QoS buffer: drains the FIFO and replays each packet MSB
// first as active-low Zeros/Ones pulses framed by an active-low Start strobe.
import qos_pkg::*;

module qos_pkt_tx #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned START_CYC  = 4,
   parameter int unsigned PULSE_CYC  = 4,
   parameter int unsigned GAP_CYC    = 4,
   parameter int unsigned IPG_CYC    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   qos_pkt_tx_if.slave      pkt_bus,
   output logic             Start,
   output logic             Zeros,
   output logic             Ones,
   output logic             busy,
   output logic [PKT_W-1:0] cur_pkt,
   output logic [7:0]       Total_Sent
);
   localparam int unsigned MAX_SP  = (START_CYC > PULSE_CYC) ? START_CYC : PULSE_CYC;
   localparam int unsigned MAX_GI  = (GAP_CYC > IPG_CYC) ? GAP_CYC : IPG_CYC;
   localparam int unsigned MAX_CYC = (MAX_SP > MAX_GI) ? MAX_SP : MAX_GI;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
   localparam int unsigned IDX_W   = $clog2(PKT_W);
   localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH + 1);

   tx_state_t         state;
   tx_state_t         state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              phase_end;
   logic [IDX_W-1:0]  idx;

   logic [PKT_W-1:0]  fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FCNT_W-1:0] fifo_count;

   logic              start_d;
   logic              zeros_d;
   logic              ones_d;
   logic              busy_d;
   logic              pop;
   logic              idx_dec;
   logic              frame_done;

   qos_pkt_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (pkt_bus.pkt_valid),
      .din   (pkt_bus.pkt_in),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign pkt_bus.pkt_ready = !fifo_full;

   // State register and per-phase cycle counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) begin
            cnt <= '0;
         end else if (state != IDLE) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Next-state: each phase lasts a fixed number of cycles
   always_comb begin
      state_nxt = state;
      phase_end = 1'b0;
      unique case (state)
         IDLE: begin
            if (fifo_count != FCNT_W'(0)) state_nxt = START;
         end
         START: begin
            phase_end = (cnt == CNT_W'(START_CYC - 1));
            if (phase_end) state_nxt = SGAP;
         end
         SGAP: begin
            phase_end = (cnt == CNT_W'(GAP_CYC - 1));
            if (phase_end) state_nxt = PULSE;
         end
         PULSE: begin
            phase_end = (cnt == CNT_W'(PULSE_CYC - 1));
            if (phase_end) state_nxt = BGAP;
         end
         BGAP: begin
            phase_end = (cnt == CNT_W'(GAP_CYC - 1));
            if (phase_end) state_nxt = (idx != IDX_W'(0)) ? PULSE : IPG;
         end
         IPG: begin
            phase_end = (cnt == CNT_W'(IPG_CYC - 1));
            if (phase_end) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode; the strobes are registered below, one cycle behind the state
   always_comb begin
      start_d    = 1'b1;
      zeros_d    = 1'b1;
      ones_d     = 1'b1;
      busy_d     = (state != IDLE);
      pop        = 1'b0;
      idx_dec    = 1'b0;
      frame_done = 1'b0;
      unique case (state)
         IDLE:  pop = !fifo_empty;
         START: start_d = 1'b0;
         PULSE: begin
            zeros_d = cur_pkt[idx];
            ones_d  = !cur_pkt[idx];
         end
         BGAP: begin
            if (phase_end) begin
               idx_dec    = (idx != IDX_W'(0));
               frame_done = (idx == IDX_W'(0));
            end
         end
         default: ;
      endcase
   end

   // Registered strobes and datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Start      <= 1'b1;
         Zeros      <= 1'b1;
         Ones       <= 1'b1;
         busy       <= 1'b0;
         cur_pkt    <= '0;
         idx        <= '0;
         Total_Sent <= '0;
      end else begin
         Start <= start_d;
         Zeros <= zeros_d;
         Ones  <= ones_d;
         busy  <= busy_d;
         if (pop) begin
            cur_pkt <= fifo_dout;
            idx     <= IDX_W'(PKT_W - 1);
         end else if (idx_dec) begin
            idx <= idx - IDX_W'(1);
         end
         if (frame_done) begin
            Total_Sent <= Total_Sent + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_qos_pkt_tx.sv
// Self-checking bench for qos_pkt_tx: a line monitor decodes frames and checks
// them against a queue of accepted packets; per-feature tasks check timing.
import qos_pkg::*;

module tb_qos_pkt_tx;

   localparam int FIFO_DEPTH = 4;
   localparam int START_CYC  = 4;
   localparam int PULSE_CYC  = 4;
   localparam int GAP_CYC    = 4;
   localparam int IPG_CYC    = 8;
   localparam int FRAME_CYC  = 49;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       Start;
   logic       Zeros;
   logic       Ones;
   logic       busy;
   logic [3:0] cur_pkt;
   logic [7:0] Total_Sent;

   qos_pkt_tx_if bus ();

   qos_pkt_tx #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .START_CYC  (START_CYC),
      .PULSE_CYC  (PULSE_CYC),
      .GAP_CYC    (GAP_CYC),
      .IPG_CYC    (IPG_CYC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pkt_bus    (bus.slave),
      .Start      (Start),
      .Zeros      (Zeros),
      .Ones       (Ones),
      .busy       (busy),
      .cur_pkt    (cur_pkt),
      .Total_Sent (Total_Sent)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_fail = 0;
   logic [3:0] exp_q [$];
   int         zeros_pulses = 0;
   int         ones_pulses = 0;
   int         frames_seen = 0;

   // Line monitor: sampled 1 time unit after each rising edge
   logic       p_start = 1'b1;
   logic       p_zeros = 1'b1;
   logic       p_ones = 1'b1;
   int         start_len = 0;
   int         pulse_len = 0;
   int         nbits = 0;
   bit         in_frame = 1'b0;
   logic [3:0] frame = '0;
   logic [3:0] exp_frame;

   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         in_frame = 1'b0;
         p_start  = 1'b1;
         p_zeros  = 1'b1;
         p_ones   = 1'b1;
      end else begin
         if (!Zeros || !Ones) begin
            n_cmp++;
            if (!Zeros && !Ones) begin
               n_fail++;
               $display("FAIL excl_strobe: Zeros=%b Ones=%b, required at most one low", Zeros, Ones);
            end else if (!Start) begin
               n_fail++;
               $display("FAIL strobe_vs_start: bit strobe low with Start=%b, required Start=1", Start);
            end
         end
         if (!Start && p_start) begin
            in_frame  = 1'b1;
            nbits     = 0;
            start_len = 0;
            frame     = '0;
         end
         if (!Start) start_len++;
         if (Start && !p_start) begin
            n_cmp++;
            if (start_len != START_CYC) begin
               n_fail++;
               $display("FAIL start_len: got %0d cycles, required %0d", start_len, START_CYC);
            end
         end
         if ((!Zeros && p_zeros) || (!Ones && p_ones)) begin
            pulse_len = 0;
            frame     = {frame[2:0], ~Ones};
            nbits++;
            if (!Zeros) zeros_pulses++;
            else        ones_pulses++;
         end
         if (!Zeros || !Ones) pulse_len++;
         if ((Zeros && !p_zeros) || (Ones && !p_ones)) begin
            n_cmp++;
            if (pulse_len != PULSE_CYC) begin
               n_fail++;
               $display("FAIL pulse_len: got %0d cycles, required %0d", pulse_len, PULSE_CYC);
            end
            if (in_frame && nbits == 4) begin
               frames_seen++;
               in_frame = 1'b0;
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL frame_unexpected: got %b with no packet outstanding", frame);
               end else begin
                  exp_frame = exp_q.pop_front();
                  if (frame !== exp_frame) begin
                     n_fail++;
                     $display("FAIL frame_data: got %b, required %b", frame, exp_frame);
                  end
               end
            end
         end
         p_start = Start;
         p_zeros = Zeros;
         p_ones  = Ones;
      end
   end

   // Drives one packet and returns right after the accepting edge; valid stays high
   task automatic push_pkt(input logic [3:0] p, input int max_wait, output int waited);
      @(negedge clk);
      bus.pkt_in    = pkt_t'(p);
      bus.pkt_valid = 1'b1;
      waited        = 0;
      while (!bus.pkt_ready && waited < max_wait) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.pkt_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL push_timeout: pkt_ready still %b after %0d cycles, required 1", bus.pkt_ready, waited);
         bus.pkt_valid = 1'b0;
      end else begin
         exp_q.push_back(p);
         @(posedge clk);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n         = 1'b0;
      bus.pkt_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.pkt_valid = 1'b0;
      bus.pkt_in    = '0;
      repeat (3) @(negedge clk);
      n_cmp += 7;
      if (Start !== 1'b1)      begin n_fail++; $display("FAIL reset_start: got %b, required 1", Start); end
      if (Zeros !== 1'b1)      begin n_fail++; $display("FAIL reset_zeros: got %b, required 1", Zeros); end
      if (Ones !== 1'b1)       begin n_fail++; $display("FAIL reset_ones: got %b, required 1", Ones); end
      if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
      if (cur_pkt !== 4'h0)    begin n_fail++; $display("FAIL reset_cur_pkt: got %h, required 0", cur_pkt); end
      if (Total_Sent !== 8'd0) begin n_fail++; $display("FAIL reset_total: got %0d, required 0", Total_Sent); end
      if (bus.pkt_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", bus.pkt_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int w;
      do_reset();
      push_pkt(4'b1101, 5, w);   // accepting edge = edge 0
      @(negedge clk);
      bus.pkt_valid = 1'b0;
      for (int e = 1; e <= 50; e++) begin
         @(negedge clk);
         if (e == 1) begin
            n_cmp += 3;
            if (Start !== 1'b1)     begin n_fail++; $display("FAIL single_start_e1: got %b, required 1", Start); end
            if (busy !== 1'b0)      begin n_fail++; $display("FAIL single_busy_e1: got %b, required 0", busy); end
            if (cur_pkt !== 4'b1101) begin n_fail++; $display("FAIL single_cur_pkt: got %b, required 1101", cur_pkt); end
         end
         if (e == 2) begin
            n_cmp += 2;
            if (Start !== 1'b0) begin n_fail++; $display("FAIL single_start_e2: got %b, required 0", Start); end
            if (busy !== 1'b1)  begin n_fail++; $display("FAIL single_busy_e2: got %b, required 1", busy); end
         end
         if (e == 5) begin
            n_cmp++;
            if (Start !== 1'b0) begin n_fail++; $display("FAIL single_start_e5: got %b, required 0", Start); end
         end
         if (e == 6) begin
            n_cmp++;
            if (Start !== 1'b1) begin n_fail++; $display("FAIL single_start_e6: got %b, required 1", Start); end
         end
         if (e == 9) begin
            n_cmp++;
            if (Ones !== 1'b1) begin n_fail++; $display("FAIL single_ones_e9: got %b, required 1", Ones); end
         end
         if (e == 10) begin
            n_cmp++;
            if (Ones !== 1'b0) begin n_fail++; $display("FAIL single_ones_e10: got %b, required 0", Ones); end
         end
         if (e == 49) begin
            n_cmp++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_e49: got %b, required 1", busy); end
         end
         if (e == 50) begin
            n_cmp += 3;
            if (busy !== 1'b0)       begin n_fail++; $display("FAIL single_busy_e50: got %b, required 0", busy); end
            if (Total_Sent !== 8'd1) begin n_fail++; $display("FAIL single_total: got %0d, required 1", Total_Sent); end
            if (cur_pkt !== 4'b1101) begin n_fail++; $display("FAIL single_cur_hold: got %b, required 1101", cur_pkt); end
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL single_outstanding: %0d packets not seen, required 0", exp_q.size());
      end
   endtask

   task automatic test_fill();
      int w;
      int c;
      int f0;
      logic [3:0] pk [6] = '{4'h3, 4'h6, 4'h9, 4'hC, 4'hE, 4'h1};
      do_reset();
      f0 = frames_seen;
      for (int i = 0; i < 5; i++) push_pkt(pk[i], 5, w);
      @(negedge clk);
      bus.pkt_valid = 1'b0;
      n_cmp++;
      if (bus.pkt_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b, required 0", bus.pkt_ready); end
      push_pkt(pk[5], 100, w);
      n_cmp++;
      if (w != 45) begin n_fail++; $display("FAIL fill_held: sixth push waited %0d cycles, required 45", w); end
      @(negedge clk);
      bus.pkt_valid = 1'b0;
      c = 0;
      while ((exp_q.size() != 0 || busy) && c < 6 * FRAME_CYC + 50) begin
         @(negedge clk);
         c++;
      end
      n_cmp += 3;
      if (exp_q.size() != 0 || busy) begin n_fail++; $display("FAIL fill_drain: %0d left busy=%b, required 0 and 0", exp_q.size(), busy); end
      if (Total_Sent !== 8'd6) begin n_fail++; $display("FAIL fill_total: got %0d, required 6", Total_Sent); end
      if (frames_seen - f0 != 6) begin n_fail++; $display("FAIL fill_frames: got %0d, required 6", frames_seen - f0); end
   endtask

   task automatic test_bits();
      int w;
      int c;
      int z0;
      int o0;
      int f0;
      do_reset();
      z0 = zeros_pulses;
      o0 = ones_pulses;
      f0 = frames_seen;
      push_pkt(4'b0000, 5, w);
      push_pkt(4'b1111, 5, w);
      @(negedge clk);
      bus.pkt_valid = 1'b0;
      c = 0;
      while (frames_seen < f0 + 1 && c < 2 * FRAME_CYC) begin @(negedge clk); c++; end
      n_cmp += 2;
      if (zeros_pulses - z0 != 4) begin n_fail++; $display("FAIL bits_zeros_first: got %0d pulses, required 4", zeros_pulses - z0); end
      if (ones_pulses - o0 != 0)  begin n_fail++; $display("FAIL bits_ones_first: got %0d pulses, required 0", ones_pulses - o0); end
      c = 0;
      while (frames_seen < f0 + 2 && c < 2 * FRAME_CYC) begin @(negedge clk); c++; end
      n_cmp += 2;
      if (zeros_pulses - z0 != 4) begin n_fail++; $display("FAIL bits_zeros_second: got %0d pulses, required 4", zeros_pulses - z0); end
      if (ones_pulses - o0 != 4)  begin n_fail++; $display("FAIL bits_ones_second: got %0d pulses, required 4", ones_pulses - o0); end
      c = 0;
      while (busy && c < FRAME_CYC) begin @(negedge clk); c++; end
   endtask

   task automatic test_reset_mid();
      int w;
      int c;
      int z0;
      int o0;
      do_reset();
      push_pkt(4'b1010, 5, w);
      @(negedge clk);
      bus.pkt_valid = 1'b0;
      c = 0;
      while (Zeros && Ones && c < FRAME_CYC) begin @(negedge clk); c++; end
      n_cmp++;
      if (Zeros && Ones) begin n_fail++; $display("FAIL mid_no_pulse: no bit pulse within %0d cycles", c); end
      rst_n         = 1'b0;
      bus.pkt_in    = pkt_t'(4'b1111);
      bus.pkt_valid = 1'b1;
      @(negedge clk);
      rst_n         = 1'b1;
      bus.pkt_valid = 1'b0;
      exp_q.delete();
      n_cmp += 6;
      if (Start !== 1'b1)      begin n_fail++; $display("FAIL mid_start: got %b, required 1", Start); end
      if (Zeros !== 1'b1)      begin n_fail++; $display("FAIL mid_zeros: got %b, required 1", Zeros); end
      if (Ones !== 1'b1)       begin n_fail++; $display("FAIL mid_ones: got %b, required 1", Ones); end
      if (busy !== 1'b0)       begin n_fail++; $display("FAIL mid_busy: got %b, required 0", busy); end
      if (Total_Sent !== 8'd0) begin n_fail++; $display("FAIL mid_total: got %0d, required 0", Total_Sent); end
      if (bus.pkt_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b, required 1", bus.pkt_ready); end
      z0 = zeros_pulses;
      o0 = ones_pulses;
      repeat (2 * FRAME_CYC) @(negedge clk);
      n_cmp += 3;
      if (zeros_pulses != z0 || ones_pulses != o0) begin
         n_fail++;
         $display("FAIL mid_quiet: got %0d new pulses after reset, required 0", (zeros_pulses - z0) + (ones_pulses - o0));
      end
      if (busy !== 1'b0)       begin n_fail++; $display("FAIL mid_busy_after: got %b, required 0", busy); end
      if (Total_Sent !== 8'd0) begin n_fail++; $display("FAIL mid_total_after: got %0d, required 0", Total_Sent); end
   endtask

   task automatic test_wrap();
      int w;
      int c;
      int f0;
      do_reset();
      f0 = frames_seen;
      for (int i = 0; i < 256; i++) push_pkt(4'(i * 7 + 3), 2 * FRAME_CYC, w);
      @(negedge clk);
      bus.pkt_valid = 1'b0;
      c = 0;
      while ((exp_q.size() != 0 || busy) && c < 6 * FRAME_CYC) begin
         @(negedge clk);
         c++;
      end
      n_cmp += 2;
      if (frames_seen - f0 != 256) begin n_fail++; $display("FAIL wrap_frames: got %0d, required 256", frames_seen - f0); end
      if (Total_Sent !== 8'd0)     begin n_fail++; $display("FAIL wrap_total: got %0d, required 0", Total_Sent); end
   endtask

   initial begin
      bus.pkt_in    = '0;
      bus.pkt_valid = 1'b0;
      test_reset();
      test_single();
      test_fill();
      test_bits();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
